sprite_pixel_mixer: RTL and testbench
=====================================

# sprite_pixel_mixer

Per-pixel compositor directly downstream of the sprite/background shift-register block. It generates the per-pixel shift enables for the 8 sprite shifters and the background shifter. It then consumes their 2-bit colour indices, resolves sprite priority and transparency, and looks up a 16-entry × 24-bit palette to produce one RGB pixel per pixel slot. It also reports sprite-to-sprite collisions.

## Interface
Parameters:
- NUM_SPRITES, 8, number of sprite shifters; background is lane NUM_SPRITES
- SPRITE_W, 16, sprite width in pixels (32-bit shifter / 2 bpp)
- X_W, 10, horizontal coordinate width
- COLOR_W, 24, palette entry width (8:8:8 RGB)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse; next pixel slot is hcount 0
- pixel_en  in  1  one pulse per displayed pixel
- sprite_x  in  [NUM_SPRITES][X_W]  sprite left edge
- sprite_valid  in  NUM_SPRITES  sprite visible on this line
- sprite_pal  in  [NUM_SPRITES][2]  palette select per sprite
- shift_en  out  NUM_SPRITES+1  enables to shifters; bit NUM_SPRITES is background
- pix_in  in  [NUM_SPRITES+1][2]  shifter outputs, valid one cycle after shift_en
- pal_we  in  1  palette write strobe
- pal_addr  in  4  palette entry {pal[1:0], idx[1:0]}
- pal_wdata  in  COLOR_W  palette write data
- collision_clr  in  1  clears collision flag
- rgb  out  COLOR_W  composited pixel
- rgb_valid  out  1  rgb holds a new pixel this cycle
- collision  out  1  sticky: ≥2 opaque sprites overlapped

## Operation
- On line_start: hcount ← 0. sprite_x, sprite_valid and sprite_pal are latched into shadow registers, so mid-line CPU writes take effect next line. No shift occurs that cycle, even if pixel_en is also high; line_start wins.
- Pixel slot (pixel_en high, line_start low):
  - shift_en[NUM_SPRITES] = 1.
  - shift_en[i] = valid_i && x_i ≤ hcount < x_i+SPRITE_W. The compare is X_W+1 bits wide, with no wrap.
  - hcount increments and saturates at all-ones.
  - shift_en is combinational from pixel_en and registered state; it is low in all other cycles.
- Stage 1 (slot+1): captures the window mask (the shift_en[i] values) and the slot valid. pix_in is sampled in this cycle.
- Priority resolve at stage 1:
  - The winner is the lowest-index i with mask[i]=1 and pix_in[i]≠0. Its entry is {pal_i, pix_in[i]}.
  - If there is no winner, the entry is {2'b00, pix_in[bg]}; background index 0 gives the backdrop entry 0.
  - Entry and valid are registered at stage 2.
- Collision: set when ≥2 sprites are opaque in the same stage-1 slot. Cleared by collision_clr; a set in the same cycle as a clear wins.
- Palette: 16×COLOR_W registers with a registered read of the stage-2 entry, so rgb and rgb_valid appear at stage 3.
  - A write is visible to reads in the following cycle. A same-cycle read of the address being written returns the old data.
- rgb holds its last value when rgb_valid is low.

## Timing
- Latency: pixel_en at cycle T gives rgb_valid at T+3. Full throughput is one pixel per cycle if pixel_en is held high.
- Reset: hcount, shadow registers, pipeline valids, rgb, rgb_valid, collision and all palette entries are 0, and shift_en is 0.
- Reset mid-line: the pipeline flushes and rgb_valid is 0 from the cycle after reset is asserted. No shift_en is issued while reset is high.
- Sprite with x_i+SPRITE_W beyond max hcount: the partial sprite is shown, with no wrap to the line start.
- A sprite enabled for fewer than SPRITE_W slots (line ended) is left with residual bits. The shifter reload before the next line handles this.

## Structure
- Package sprite_pkg holds:
  - NUM_SPRITES, SPRITE_W, X_W, COLOR_W
  - typedef pix_t (2-bit index)
  - typedef pal_entry_t (4-bit {pal, idx})
- Sub-module sprite_palette_ram: 16×COLOR_W, one write port and one registered read port, reset to zero.
- Priority resolve and collision detection are inline combinational logic in the top module.

## Test plan
- Sprite 0 at x=5, valid, pal=1, all pixels index 2; background index 1; palette[6]=0xFF0000, palette[1]=0x0000FF → hcount 0–4 and 21+ give 0x0000FF; hcount 5–20 give 0xFF0000; each rgb_valid 3 cycles after its pixel_en.
- Sprites 0 and 3 both at x=10 and opaque → sprite 0 colour is output, collision=1; collision_clr pulsed in the same cycle as a new overlap → collision stays 1.
- Sprite 2 pixel index 0 over background index 3 → background colour palette[3] is shown (transparency).
- sprite_x changed mid-line → no effect until after the next line_start; line_start with pixel_en in the same cycle → no shift_en, hcount=0.
- Sprite at x=1015 with X_W=10 → shift_en[i] high for hcount 1015–1023 only; no enable at the next line's hcount 0–6.
- Reset asserted mid-line → rgb_valid 0 the next cycle, all palette entries read 0, shift_en stays 0 while reset is high.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes and pixel/palette-entry types for the sprite mixer
package sprite_pkg;
  localparam int NUM_SPRITES = 8;
  localparam int SPRITE_W = 16;
  localparam int X_W = 10;
  localparam int COLOR_W = 24;
  typedef logic [1:0] pix_t;
  typedef logic [3:0] pal_entry_t;
endpackage

// File: rtl/sprite_palette_ram.sv
// sprite_palette_ram: 16-entry colour palette, one write port, one registered read port
module sprite_palette_ram #(
  parameter int COLOR_W = sprite_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [3:0]         i_waddr,
  input  logic [COLOR_W-1:0] i_wdata,
  input  logic               i_rd_en,
  input  logic [3:0]         i_raddr,
  output logic [COLOR_W-1:0] o_rdata
);
  logic [COLOR_W-1:0] r_mem [16];
  // palette storage; a write lands at the clock edge, so a same-edge read sees old data
  always_ff @(posedge clk) begin
    if (reset) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  // read register only advances on valid pixels so the output holds between pixels
  always_ff @(posedge clk) begin
    if (reset) o_rdata <= '0;
    else if (i_rd_en) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sprite_pixel_mixer.sv
// sprite_pixel_mixer: sprite window enables, priority/transparency resolve and palette lookup
module sprite_pixel_mixer #(
  parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int X_W = sprite_pkg::X_W,
  parameter int COLOR_W = sprite_pkg::COLOR_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                line_start,
  input  logic                                pixel_en,
  input  logic [NUM_SPRITES-1:0][X_W-1:0]     sprite_x,
  input  logic [NUM_SPRITES-1:0]              sprite_valid,
  input  logic [NUM_SPRITES-1:0][1:0]         sprite_pal,
  output logic [NUM_SPRITES:0]                shift_en,
  input  logic [NUM_SPRITES:0][1:0]           pix_in,
  input  logic                                pal_we,
  input  logic [3:0]                          pal_addr,
  input  logic [COLOR_W-1:0]                  pal_wdata,
  input  logic                                collision_clr,
  output logic [COLOR_W-1:0]                  rgb,
  output logic                                rgb_valid,
  output logic                                collision
);
  import sprite_pkg::*;
  logic [X_W-1:0]                  r_hcount;
  logic [NUM_SPRITES-1:0][X_W-1:0] r_sx;
  logic [NUM_SPRITES-1:0]          r_sv, r_mask, w_win, w_opaque;
  logic [NUM_SPRITES-1:0][1:0]     r_sp, r_pal1;
  logic                            r_v1, r_v2, r_v3, r_col, w_slot, w_multi;
  pal_entry_t                      r_entry, w_entry;
  pix_t                            w_bg;
  assign w_slot = pixel_en & ~line_start & ~reset;
  assign w_bg = pix_in[NUM_SPRITES];
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_lane
    assign w_win[i] = r_sv[i] && ({1'b0, r_hcount} >= {1'b0, r_sx[i]})
                      && ({1'b0, r_hcount} < {1'b0, r_sx[i]} + (X_W+1)'(SPRITE_W));
    assign w_opaque[i] = r_mask[i] && (pix_in[i] != 2'b00);
  end
  assign shift_en = w_slot ? {1'b1, w_win} : '0;
  assign w_multi = |(w_opaque & (w_opaque - NUM_SPRITES'(1)));
  assign rgb_valid = r_v3;
  assign collision = r_col;
  // lowest-index opaque sprite wins; otherwise the background index selects from palette 0
  always_comb begin
    w_entry = {2'b00, w_bg};
    for (int i = NUM_SPRITES-1; i >= 0; i--) w_entry = w_opaque[i] ? {r_pal1[i], pix_in[i]} : w_entry;
  end
  // horizontal counter and per-line shadow copy of the sprite table
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount <= '0;
      r_sx <= '0;
      r_sv <= '0;
      r_sp <= '0;
    end else if (line_start) begin
      r_hcount <= '0;
      r_sx <= sprite_x;
      r_sv <= sprite_valid;
      r_sp <= sprite_pal;
    end else if (pixel_en && r_hcount != '1) r_hcount <= r_hcount + 1'b1;
  end
  // pixel pipeline: stage 1 window mask, stage 2 palette entry, stage 3 valid alongside rgb
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_pal1 <= '0;
      r_v1 <= 1'b0;
      r_entry <= '0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      r_mask <= shift_en[NUM_SPRITES-1:0];
      r_pal1 <= r_sp;
      r_v1 <= shift_en[NUM_SPRITES];
      r_entry <= w_entry;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end
  // sticky collision flag; a new overlap beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) r_col <= 1'b0;
    else if (w_multi) r_col <= 1'b1;
    else if (collision_clr) r_col <= 1'b0;
  end
  sprite_palette_ram #(.COLOR_W(COLOR_W)) u_pal (
    .clk(clk),
    .reset(reset),
    .i_we(pal_we),
    .i_waddr(pal_addr),
    .i_wdata(pal_wdata),
    .i_rd_en(r_v2),
    .i_raddr(r_entry),
    .o_rdata(rgb)
  );
endmodule

// File: tb/tb_sprite_pixel_mixer.sv
// tb_sprite_pixel_mixer: scoreboard plus window table for the sprite pixel mixer
module tb_sprite_pixel_mixer;
  import sprite_pkg::*;
  localparam int N = NUM_SPRITES;
  logic clk = 0, reset = 1, line_start = 0, pixel_en = 0, pal_we = 0, collision_clr = 0;
  logic [N-1:0][X_W-1:0] sprite_x = '0;
  logic [N-1:0] sprite_valid = '0;
  logic [N-1:0][1:0] sprite_pal = '0;
  logic [N:0] shift_en;
  logic [N:0][1:0] pix_in = '0;
  logic [3:0] pal_addr = '0;
  logic [COLOR_W-1:0] pal_wdata = '0, rgb;
  logic rgb_valid, collision;

  sprite_pixel_mixer dut (
    .clk(clk), .reset(reset), .line_start(line_start), .pixel_en(pixel_en),
    .sprite_x(sprite_x), .sprite_valid(sprite_valid), .sprite_pal(sprite_pal),
    .shift_en(shift_en), .pix_in(pix_in), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .collision_clr(collision_clr), .rgb(rgb),
    .rgb_valid(rgb_valid), .collision(collision)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [23:0] rgb; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [23:0] last_rgb = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rgb_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rgb_unexpected: got rgb %0h with no pending pixel", rgb);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rgb", rgb, e.rgb);
        chk("latency", cyc, e.due);
        last_rgb = e.rgb;
      end
    end
  end

  // reference model state: live CPU-side table, per-line shadow, palette
  int m_x[N], s_x[N], m_p[N], s_p[N], m_h = 0;
  bit m_v[N], s_v[N], m_col = 0;
  logic [1:0] m_pix[N+1];
  logic [23:0] m_pal[16];
  logic [N:0] last_se;

  task automatic set_inputs();
    for (int i = 0; i < N; i++) begin
      sprite_x[i] = X_W'(m_x[i]);
      sprite_valid[i] = m_v[i];
      sprite_pal[i] = 2'(m_p[i]);
    end
    for (int i = 0; i <= N; i++) pix_in[i] = m_pix[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input bit clr);
    logic [N:0] en;
    int cnt;
    logic [3:0] ent;
    set_inputs();
    pixel_en = 1;
    collision_clr = clr;
    en = '0;
    en[N] = 1'b1;
    cnt = 0;
    ent = {2'b00, m_pix[N]};
    for (int i = N-1; i >= 0; i--) begin
      en[i] = s_v[i] && m_h >= s_x[i] && m_h < s_x[i] + SPRITE_W;
      if (en[i] && m_pix[i] != 0) begin
        cnt++;
        ent = {2'(s_p[i]), m_pix[i]};
      end
    end
    #1;
    last_se = shift_en;
    chk("shift_en", shift_en, en);
    q.push_back('{cyc + 3, m_pal[ent]});
    if (cnt >= 2) m_col = 1;
    @(posedge clk);
    #1;
    pixel_en = 0;
    collision_clr = 0;
    if (m_h < 1023) m_h++;
  endtask

  task automatic new_line(input bit with_pe);
    set_inputs();
    line_start = 1;
    pixel_en = with_pe;
    #1;
    chk("shift_en_linestart", shift_en, '0);
    step();
    line_start = 0;
    pixel_en = 0;
    s_x = m_x;
    s_v = m_v;
    s_p = m_p;
    m_h = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pixels still pending, required 0", q.size());
      q.delete();
    end
    step();
  endtask

  task automatic pal_wr(input int a, input logic [23:0] d);
    pal_we = 1;
    pal_addr = 4'(a);
    pal_wdata = d;
    step();
    pal_we = 0;
    m_pal[a] = d;
  endtask

  task automatic clear_sprites();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0;
      m_v[i] = 0;
      m_p[i] = 0;
      m_pix[i] = 0;
    end
  endtask

  typedef struct { int x; int h; bit en; } win_t;
  win_t tbl [11];

  initial begin
    tbl = '{'{5, 4, 0}, '{5, 5, 1}, '{5, 20, 1}, '{5, 21, 0}, '{0, 0, 1}, '{0, 15, 1},
            '{0, 16, 0}, '{1015, 1014, 0}, '{1015, 1015, 1}, '{1015, 1023, 1}, '{1023, 1023, 1}};
    clear_sprites();
    m_pix[N] = 0;
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    s_x = m_x;
    s_v = m_v;
    s_p = m_p;
    pixel_en = 1;
    repeat (3) step();
    chk("shift_en_in_reset", shift_en, '0);
    pixel_en = 0;
    reset = 0;
    step();
    chk("reset_rgb", rgb, '0);
    chk("reset_rgb_valid", rgb_valid, 0);
    chk("reset_collision", collision, 0);
    chk("reset_shift_en", shift_en, '0);

    // single sprite over background
    pal_wr(6, 24'hFF0000);
    pal_wr(1, 24'h0000FF);
    m_x[0] = 5; m_v[0] = 1; m_p[0] = 1; m_pix[0] = 2; m_pix[N] = 1;
    new_line(0);
    for (int h = 0; h < 25; h++) slot(0);
    drain();
    repeat (3) step();
    chk("rgb_hold", rgb, last_rgb);
    chk("rgb_valid_idle", rgb_valid, 0);
    chk("no_collision", collision, m_col);

    // two opaque sprites overlapping: lower index wins, collision sticks through a clear
    pal_wr(11, 24'h00FF00);
    m_x[0] = 10; m_x[3] = 10; m_v[3] = 1; m_p[3] = 2; m_pix[3] = 3;
    new_line(0);
    for (int h = 0; h < 12; h++) slot(0);
    drain();
    chk("collision_set", collision, m_col);
    new_line(0);
    for (int h = 0; h < 16; h++) slot(h == 13);
    drain();
    chk("collision_clr_vs_set", collision, m_col);
    collision_clr = 1;
    step();
    collision_clr = 0;
    m_col = 0;
    chk("collision_cleared", collision, m_col);

    // transparent sprite pixel shows background colour
    clear_sprites();
    pal_wr(3, 24'h123456);
    pal_wr(8, 24'hABCDEF);
    m_v[2] = 1; m_p[2] = 2; m_pix[2] = 0; m_pix[N] = 3;
    new_line(0);
    for (int h = 0; h < 5; h++) slot(0);
    drain();
    chk("transparent_collision", collision, 0);

    // mid-line sprite_x write waits for line_start; line_start beats pixel_en
    clear_sprites();
    m_x[0] = 5; m_v[0] = 1; m_p[0] = 1; m_pix[0] = 2; m_pix[N] = 1;
    new_line(0);
    for (int h = 0; h < 3; h++) slot(0);
    m_x[0] = 1;
    for (int h = 0; h < 8; h++) slot(0);
    new_line(1);
    slot(0);
    chk("hcount0_x1", last_se[0], 0);
    slot(0);
    chk("hcount1_x1", last_se[0], 1);
    drain();

    // window boundary table, including the right-edge partial sprite
    clear_sprites();
    m_pix[N] = 2;
    m_v[1] = 1; m_p[1] = 3; m_pix[1] = 1;
    foreach (tbl[k]) begin
      m_x[1] = tbl[k].x;
      new_line(0);
      for (int h = 0; h <= tbl[k].h; h++) slot(0);
      chk($sformatf("win_tbl_%0d", k), last_se[1], tbl[k].en);
      drain();
    end
    m_x[1] = 1015;
    new_line(0);
    for (int h = 0; h < 1030; h++) slot(0);
    chk("saturated_en", last_se[1], 1);
    new_line(0);
    for (int h = 0; h < 7; h++) begin
      slot(0);
      chk("no_wrap", last_se[1], 0);
    end
    drain();

    // palette write on the same edge as the read returns old data, next read new
    clear_sprites();
    m_pix[N] = 2;
    pal_wr(2, 24'h00AAAA);
    new_line(0);
    slot(0);
    step();
    pal_wr(2, 24'h00BBBB);
    drain();
    slot(0);
    drain();

    // reset mid-line flushes pipeline and clears palette
    m_x[0] = 0; m_v[0] = 1; m_p[0] = 1; m_pix[0] = 2;
    new_line(0);
    for (int h = 0; h < 3; h++) slot(0);
    reset = 1;
    pixel_en = 1;
    #1;
    chk("shift_en_reset_mid", shift_en, '0);
    step();
    chk("rgb_valid_after_reset", rgb_valid, 0);
    chk("shift_en_reset_held", shift_en, '0);
    q.delete();
    step();
    reset = 0;
    pixel_en = 0;
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    for (int i = 0; i < N; i++) begin s_x[i] = 0; s_v[i] = 0; s_p[i] = 0; end
    m_h = 0;
    m_col = 0;
    chk("collision_after_reset", collision, 0);
    chk("rgb_after_reset", rgb, 0);
    for (int e = 0; e < 16; e++) begin
      m_p[0] = e >> 2;
      m_pix[0] = 2'(e);
      m_pix[N] = 2'(e);
      new_line(0);
      slot(0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
